// File: rtl/nes_mem_arbiter_if.sv
// External memory port: req/ack handshake with registered request fields.
// The arbiter drives the master side, the memory controller the slave side.
interface nes_mem_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/nes_mem_arbiter.sv
// Shares one memory port between the NES CPU (rd/wr) and PPU (rd): latches strobes,
// serialises them with PPU priority bounded by a CPU anti-starvation streak limit.
module nes_mem_arbiter #(
    parameter int ADDR_W         = 22,
    parameter int DATA_W         = 8,
    parameter int MAX_PPU_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ppu_rd,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] ppu_din,
    output logic              cpu_done,
    output logic              ppu_done,
    output logic              cpu_busy,
    output logic              ppu_busy,
    output logic              overrun,
    nes_mem_arbiter_if.master mem
);
    localparam int SW = $clog2(MAX_PPU_STREAK + 1);

    typedef struct packed {
        logic              pend;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    slot_t             cpu_slot, ppu_slot, cpu_eff, ppu_eff;
    logic              cpu_stb, grant, gnt_cpu, ack_fire, owner_cpu;
    logic [SW-1:0]     streak;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign cpu_stb  = cpu_rd | cpu_wr;
    assign cpu_busy = cpu_slot.pend;
    assign ppu_busy = ppu_slot.pend;

    assign mem.req   = (state == BUSY);
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    // Effective slot view includes a strobe arriving this cycle, so an idle
    // arbiter can grant it on the same edge that captures it.
    always_comb begin
        cpu_eff = cpu_slot;
        ppu_eff = ppu_slot;
        if (!cpu_slot.pend && cpu_stb)
            cpu_eff = '{pend: 1'b1, we: cpu_wr, addr: cpu_addr, wdata: cpu_wdata};
        if (!ppu_slot.pend && ppu_rd)
            ppu_eff = '{pend: 1'b1, we: 1'b0, addr: ppu_addr, wdata: '0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        gnt_cpu   = 1'b0;
        ack_fire  = 1'b0;
        case (state)
            IDLE: if (cpu_eff.pend || ppu_eff.pend) begin
                grant     = 1'b1;
                gnt_cpu   = cpu_eff.pend && (!ppu_eff.pend || streak == SW'(MAX_PPU_STREAK));
                state_nxt = BUSY;
            end
            BUSY: if (mem.ack) begin
                ack_fire  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_slot <= '0;
            ppu_slot <= '0;
            overrun  <= 1'b0;
        end else begin
            cpu_slot <= cpu_eff;
            ppu_slot <= ppu_eff;
            if (ack_fire && owner_cpu)  cpu_slot.pend <= 1'b0;
            if (ack_fire && !owner_cpu) ppu_slot.pend <= 1'b0;
            if ((cpu_stb && cpu_slot.pend) || (ppu_rd && ppu_slot.pend))
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_cpu <= 1'b0;
            streak    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_done  <= 1'b0;
            ppu_done  <= 1'b0;
            cpu_din   <= '0;
            ppu_din   <= '0;
        end else begin
            cpu_done <= 1'b0;
            ppu_done <= 1'b0;
            if (grant) begin
                owner_cpu <= gnt_cpu;
                if (gnt_cpu) begin
                    we_q    <= cpu_eff.we;
                    addr_q  <= cpu_eff.addr;
                    wdata_q <= cpu_eff.wdata;
                    streak  <= '0;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= ppu_eff.addr;
                    wdata_q <= '0;
                    if (!cpu_eff.pend)
                        streak <= '0;
                    else if (streak != SW'(MAX_PPU_STREAK))
                        streak <= streak + 1'b1;
                end
            end
            if (ack_fire) begin
                if (owner_cpu) begin
                    cpu_done <= 1'b1;
                    if (!we_q) cpu_din <= mem.rdata;
                end else begin
                    ppu_done <= 1'b1;
                    ppu_din  <= mem.rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed bench for nes_mem_arbiter: per-cycle vector table plus hand sequences
// for reset mid-access, PPU streak limit and overrun.
module tb_nes_mem_arbiter;
    localparam int AW = 22;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd, cpu_wr, ppu_rd;
    logic [AW-1:0] cpu_addr, ppu_addr;
    logic [DW-1:0] cpu_wdata, cpu_din, ppu_din;
    logic          cpu_done, ppu_done, cpu_busy, ppu_busy, overrun;

    int n_chk  = 0;
    int n_fail = 0;

    nes_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

    nes_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PPU_STREAK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ppu_rd(ppu_rd), .ppu_addr(ppu_addr),
        .cpu_din(cpu_din), .ppu_din(ppu_din), .cpu_done(cpu_done), .ppu_done(ppu_done),
        .cpu_busy(cpu_busy), .ppu_busy(ppu_busy), .overrun(overrun),
        .mem(mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          crd, cwr, prd, ack;
        logic [AW-1:0] caddr, paddr;
        logic [DW-1:0] cwd, rdata;
        logic          ereq, ewe, ecd, epd, ecb, epb;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd, ecdin, epdin;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic crd, logic cwr, logic [AW-1:0] caddr, logic [DW-1:0] cwd,
                                logic prd, logic [AW-1:0] paddr, logic ack, logic [DW-1:0] rdata,
                                logic ereq, logic ewe, logic [AW-1:0] eaddr, logic [DW-1:0] ewd,
                                logic ecd, logic epd, logic ecb, logic epb,
                                logic [DW-1:0] ecdin, logic [DW-1:0] epdin);
        vec_t v;
        v.crd = crd; v.cwr = cwr; v.caddr = caddr; v.cwd = cwd;
        v.prd = prd; v.paddr = paddr; v.ack = ack; v.rdata = rdata;
        v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
        v.ecd = ecd; v.epd = epd; v.ecb = ecb; v.epb = epb;
        v.ecdin = ecdin; v.epdin = epdin;
        return v;
    endfunction

    // Request fields only matter while mem.req is high.
    function automatic logic [63:0] pk(logic req, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd,
                                       logic cd, logic pd, logic cb, logic pb,
                                       logic [DW-1:0] cdin, logic [DW-1:0] pdin, logic ovr);
        if (!req) begin we = 1'b0; addr = '0; wd = '0; end
        return 64'({req, we, addr, wd, cd, pd, cb, pb, cdin, pdin, ovr});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_rd = 0; cpu_wr = 0; ppu_rd = 0; mem.ack = 0;
    endtask

    // Both requesters strobe together; PPU re-strobes on every ppu_done until the CPU wins.
    task automatic run_streak(input string name);
        int  n_ppu = 0;
        bit  cpu_gnt = 0, fin = 0;
        @(negedge clk);
        cpu_rd = 1; cpu_addr = 22'h55; ppu_rd = 1; ppu_addr = 22'h100;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            idle_inputs();
            if (cpu_done) fin = 1;
            if (mem.req) begin
                if (mem.addr == 22'h55) cpu_gnt = 1;
                else if (!cpu_gnt) n_ppu++;
                mem.ack = 1; mem.rdata = mem.addr[7:0];
            end
            if (ppu_done && !cpu_gnt) begin
                ppu_rd = 1; ppu_addr = 22'h100 + 22'(n_ppu);
            end
        end
        chk({name, "_done"}, 64'(fin), 64'd1);
        chk({name, "_ppu_grants"}, 64'(n_ppu), 64'd4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            idle_inputs();
            if (mem.req) mem.ack = 1;
        end
        chk({name, "_drained"}, 64'({cpu_busy, ppu_busy, mem.req}), 64'd0);
    endtask

    initial begin
        int done_cnt;
        reset = 1; idle_inputs();
        cpu_addr = '0; ppu_addr = '0; cpu_wdata = '0; mem.rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", pk(mem.req, mem.we, mem.addr, mem.wdata, cpu_done, ppu_done,
                              cpu_busy, ppu_busy, cpu_din, ppu_din, overrun), 64'd0);
        reset = 0;

        // Reset asserted while a read is in flight
        @(negedge clk); cpu_rd = 1; cpu_addr = 22'h40;
        @(negedge clk); idle_inputs();
        chk("rst_pre_req", 64'({mem.req, cpu_busy}), 64'b11);
        @(posedge clk); #2 reset = 1;
        #1 chk("rst_mid_busy", 64'({mem.req, cpu_busy, cpu_done}), 64'd0);
        @(negedge clk); reset = 0; mem.ack = 1;
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            done_cnt += int'(cpu_done) + int'(ppu_done) + int'(mem.req);
        end
        mem.ack = 0;
        chk("rst_no_done", 64'(done_cnt), 64'd0);

        tbl[0]  = mk(0,1,22'h123,8'h5A, 0,0,     0,0,     0,0,0,0,          0,0,0,0, 8'h00,8'h00);
        tbl[1]  = mk(0,0,0,0,           0,0,     1,8'hEE, 1,1,22'h123,8'h5A, 0,0,1,0, 8'h00,8'h00);
        tbl[2]  = mk(0,0,0,0,           0,0,     0,0,     0,0,0,0,          1,0,0,0, 8'h00,8'h00);
        tbl[3]  = mk(1,0,22'h10,0,      1,22'h2000,0,0,   0,0,0,0,          0,0,0,0, 8'h00,8'h00);
        tbl[4]  = mk(0,0,0,0,           0,0,     1,8'hBB, 1,0,22'h2000,0,   0,0,1,1, 8'h00,8'h00);
        tbl[5]  = mk(0,0,0,0,           0,0,     0,0,     0,0,0,0,          0,1,1,0, 8'h00,8'hBB);
        tbl[6]  = mk(0,0,0,0,           0,0,     0,0,     1,0,22'h10,0,     0,0,1,0, 8'h00,8'hBB);
        tbl[7]  = mk(0,0,0,0,           0,0,     1,8'hAA, 1,0,22'h10,0,     0,0,1,0, 8'h00,8'hBB);
        tbl[8]  = mk(0,0,0,0,           0,0,     0,0,     0,0,0,0,          1,0,0,0, 8'hAA,8'hBB);
        tbl[9]  = mk(0,0,0,0,           0,0,     0,0,     0,0,0,0,          0,0,0,0, 8'hAA,8'hBB);
        tbl[10] = mk(0,0,0,0,           1,22'h3FF,0,0,    0,0,0,0,          0,0,0,0, 8'hAA,8'hBB);
        for (int i = 11; i <= 16; i++)
            tbl[i] = mk(0,0,0,0,        0,0,     0,0,     1,0,22'h3FF,0,    0,0,0,1, 8'hAA,8'hBB);
        tbl[17] = mk(0,0,0,0,           0,0,     1,8'h77, 1,0,22'h3FF,0,    0,0,0,1, 8'hAA,8'hBB);
        tbl[18] = mk(0,0,0,0,           0,0,     0,0,     0,0,0,0,          0,1,0,0, 8'hAA,8'h77);
        tbl[19] = mk(0,0,0,0,           0,0,     1,8'h11, 0,0,0,0,          0,0,0,0, 8'hAA,8'h77);
        tbl[20] = mk(0,0,0,0,           0,0,     0,0,     0,0,0,0,          0,0,0,0, 8'hAA,8'h77);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                pk(mem.req, mem.we, mem.addr, mem.wdata, cpu_done, ppu_done,
                   cpu_busy, ppu_busy, cpu_din, ppu_din, overrun),
                pk(tbl[i].ereq, tbl[i].ewe, tbl[i].eaddr, tbl[i].ewd, tbl[i].ecd, tbl[i].epd,
                   tbl[i].ecb, tbl[i].epb, tbl[i].ecdin, tbl[i].epdin, 1'b0));
            cpu_rd = tbl[i].crd; cpu_wr = tbl[i].cwr; cpu_addr = tbl[i].caddr;
            cpu_wdata = tbl[i].cwd; ppu_rd = tbl[i].prd; ppu_addr = tbl[i].paddr;
            mem.ack = tbl[i].ack; mem.rdata = tbl[i].rdata;
        end
        @(negedge clk); idle_inputs();

        // Second run also shows the streak was cleared by the CPU grant
        run_streak("streak1");
        run_streak("streak2");

        // Overrun: second CPU strobe while the first is still in flight
        @(negedge clk); cpu_rd = 1; cpu_addr = 22'h777;
        @(negedge clk); cpu_rd = 1; cpu_addr = 22'h999;
        @(negedge clk); idle_inputs();
        chk("ovr_set", 64'({overrun, mem.req, mem.addr}), 64'({1'b1, 1'b1, 22'h777}));
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            mem.ack = 0;
            done_cnt += int'(cpu_done);
            if (c == 1) begin mem.ack = 1; mem.rdata = 8'h99; end
        end
        chk("ovr_one_done", 64'(done_cnt), 64'd1);
        chk("ovr_sticky", 64'({overrun, cpu_busy, cpu_din}), 64'({1'b1, 1'b0, 8'h99}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
